// File: rtl/regfile_rename_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : regfile_rename_ctrl
// Brief    : Register-file zero-init sequencer, rename busy/tag table and
//            issue operand lookup with same-cycle commit bypass.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module regfile_rename_ctrl #(
   parameter int REG_NUM    = 32,
   parameter int ADDR_W     = 5,
   parameter int ENTRY_SIZE = 4
) (
   input  logic                  clk,
   input  logic                  rst_in,
   input  logic                  rdy_in,
   input  logic                  flush,
   input  logic                  issue_valid,
   input  logic [ADDR_W-1:0]     issue_rd,
   input  logic [ENTRY_SIZE-1:0] issue_tag,
   output logic                  issue_ready,
   input  logic                  commit_valid,
   input  logic [ADDR_W-1:0]     commit_rd,
   input  logic [ENTRY_SIZE-1:0] commit_tag,
   input  logic [31:0]           commit_data,
   input  logic [ADDR_W-1:0]     rs1_addr,
   output logic                  rs1_busy,
   output logic [ENTRY_SIZE-1:0] rs1_tag,
   output logic                  rs1_fwd,
   output logic [31:0]           rs1_fwd_data,
   input  logic [ADDR_W-1:0]     rs2_addr,
   output logic                  rs2_busy,
   output logic [ENTRY_SIZE-1:0] rs2_tag,
   output logic                  rs2_fwd,
   output logic [31:0]           rs2_fwd_data,
   output logic                  rf_we,
   output logic [ADDR_W-1:0]     rf_waddr,
   output logic [31:0]           rf_wdata
);

   localparam logic [0:0]        c_ST_INIT  = 1'b0;
   localparam logic [0:0]        c_ST_RUN   = 1'b1;
   localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(REG_NUM - 1);

   logic [0:0]            r_state;
   logic [0:0]            w_state_nxt;
   logic [ADDR_W-1:0]     r_init_cnt;
   logic [REG_NUM-1:0]    r_busy;
   logic [ENTRY_SIZE-1:0] r_tag [REG_NUM];

   logic                  w_run;
   logic                  w_upd;
   logic                  w_commit_eff;
   logic                  w_commit_hit;
   logic [REG_NUM-1:0]    w_set;
   logic [REG_NUM-1:0]    w_clr;

   assign w_run        = (r_state == c_ST_RUN);
   assign w_upd        = w_run & rdy_in;
   assign w_commit_eff = w_upd & commit_valid;
   assign w_commit_hit = w_commit_eff & r_busy[commit_rd] &
                         (r_tag[commit_rd] == commit_tag);

   // FSM state register
   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_state <= c_ST_INIT;
      end else if (rdy_in) begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next-state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_INIT: if (r_init_cnt == c_LAST_IDX) w_state_nxt = c_ST_RUN;
         default:   w_state_nxt = r_state;
      endcase
   end

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_init_cnt <= '0;
      end else if (rdy_in && (r_state == c_ST_INIT)) begin
         r_init_cnt <= r_init_cnt + ADDR_W'(1);
      end
   end

   // FSM outputs; everything is forced low while reset is held
   always_comb begin
      issue_ready = 1'b0;
      rf_we       = 1'b0;
      rf_waddr    = '0;
      rf_wdata    = '0;
      if (rst_in) begin
         case (r_state)
            c_ST_INIT: begin
               rf_we    = rdy_in;
               rf_waddr = r_init_cnt;
            end
            c_ST_RUN: begin
               issue_ready = 1'b1;
               rf_we       = commit_valid & rdy_in & (commit_rd != '0);
               rf_waddr    = commit_rd;
               rf_wdata    = commit_data;
            end
            default: ;
         endcase
      end
   end

   // Per-register set/clear; an issue overrides a same-cycle commit clear
   generate
      for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_entry
         localparam logic [ADDR_W-1:0] c_IDX = ADDR_W'(gi);
         if (gi == 0) begin : g_zero
            assign w_set[gi] = 1'b0;
            assign w_clr[gi] = 1'b0;
         end else begin : g_reg
            assign w_set[gi] = w_upd & ~flush & issue_valid & (issue_rd == c_IDX);
            assign w_clr[gi] = w_upd & (flush | (w_commit_hit & (commit_rd == c_IDX)));
         end
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_in) begin
      if (!rst_in) begin
         r_busy <= '0;
         for (int i = 0; i < REG_NUM; i++) r_tag[i] <= '0;
      end else begin
         for (int i = 0; i < REG_NUM; i++) begin
            if (w_set[i]) begin
               r_busy[i] <= 1'b1;
               r_tag[i]  <= issue_tag;
            end else if (w_clr[i]) begin
               r_busy[i] <= 1'b0;
            end
         end
      end
   end

   // Operand lookups: a matching commit this cycle turns busy into a bypass
   logic w_rs1_ent_busy;
   logic w_rs2_ent_busy;

   assign w_rs1_ent_busy = w_run & (rs1_addr != '0) & r_busy[rs1_addr];
   assign w_rs2_ent_busy = w_run & (rs2_addr != '0) & r_busy[rs2_addr];

   assign rs1_fwd      = w_rs1_ent_busy & w_commit_eff & (commit_rd == rs1_addr) &
                         (commit_tag == r_tag[rs1_addr]);
   assign rs2_fwd      = w_rs2_ent_busy & w_commit_eff & (commit_rd == rs2_addr) &
                         (commit_tag == r_tag[rs2_addr]);
   assign rs1_busy     = w_rs1_ent_busy & ~rs1_fwd;
   assign rs2_busy     = w_rs2_ent_busy & ~rs2_fwd;
   assign rs1_tag      = r_tag[rs1_addr];
   assign rs2_tag      = r_tag[rs2_addr];
   assign rs1_fwd_data = commit_data;
   assign rs2_fwd_data = commit_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_rename_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_regfile_rename_ctrl
// Brief    : Directed plus random bench against an array-based rename model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_regfile_rename_ctrl;

   localparam int REG_NUM = 32;
   localparam int ADDR_W  = 5;
   localparam int ES      = 4;

   logic          clk = 1'b0;
   logic          rst_in, rdy_in, flush, issue_valid, commit_valid;
   logic [ADDR_W-1:0] issue_rd, commit_rd, rs1_addr, rs2_addr, rf_waddr;
   logic [ES-1:0] issue_tag, commit_tag, rs1_tag, rs2_tag;
   logic [31:0]   commit_data, rs1_fwd_data, rs2_fwd_data, rf_wdata;
   logic          issue_ready, rs1_busy, rs1_fwd, rs2_busy, rs2_fwd, rf_we;

   always #5 clk = ~clk;

   regfile_rename_ctrl #(.REG_NUM(REG_NUM), .ADDR_W(ADDR_W), .ENTRY_SIZE(ES)) dut (
      .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
      .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_tag(issue_tag),
      .issue_ready(issue_ready),
      .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_tag(commit_tag),
      .commit_data(commit_data),
      .rs1_addr(rs1_addr), .rs1_busy(rs1_busy), .rs1_tag(rs1_tag), .rs1_fwd(rs1_fwd),
      .rs1_fwd_data(rs1_fwd_data),
      .rs2_addr(rs2_addr), .rs2_busy(rs2_busy), .rs2_tag(rs2_tag), .rs2_fwd(rs2_fwd),
      .rs2_fwd_data(rs2_fwd_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference model: architectural view of the rename table
   bit m_busy [REG_NUM];
   int m_tag  [REG_NUM];
   int m_cnt;
   bit m_run;

   logic          o_we, o_ready, o_b1, o_f1, o_b2;
   logic [ES-1:0] o_t1;
   logic [31:0]   o_fd1;
   logic [ADDR_W-1:0] o_wa;

   function automatic void model_reset();
      for (int i = 0; i < REG_NUM; i++) begin
         m_busy[i] = 1'b0;
         m_tag[i]  = 0;
      end
      m_cnt = 0;
      m_run = 1'b0;
   endfunction

   function automatic void look(input int a, output bit b, output bit f);
      b = 1'b0;
      f = 1'b0;
      if (m_run && a != 0 && m_busy[a]) begin
         b = 1'b1;
         if (rdy_in && commit_valid && int'(commit_rd) == a && int'(commit_tag) == m_tag[a]) begin
            b = 1'b0;
            f = 1'b1;
         end
      end
   endfunction

   function automatic void model_clock();
      if (!m_run) begin
         if (rdy_in) begin
            m_cnt++;
            if (m_cnt == REG_NUM) begin
               m_run = 1'b1;
               m_cnt = 0;
            end
         end
      end else if (rdy_in) begin
         if (flush) begin
            for (int i = 0; i < REG_NUM; i++) m_busy[i] = 1'b0;
         end else begin
            if (commit_valid && m_busy[commit_rd] && m_tag[commit_rd] == int'(commit_tag))
               m_busy[commit_rd] = 1'b0;
            if (issue_valid && issue_rd != 0) begin
               m_busy[issue_rd] = 1'b1;
               m_tag[issue_rd]  = int'(issue_tag);
            end
         end
      end
   endfunction

   // Inputs are applied just after a rising edge; check mid-cycle, then clock.
   task automatic step();
      bit eb1, ef1, eb2, ef2, ewe;
      int ewa;
      logic [31:0] ewd;
      #3;
      if (m_run) begin
         ewe = rdy_in && commit_valid && commit_rd != 0;
         ewa = int'(commit_rd);
         ewd = commit_data;
      end else begin
         ewe = rdy_in;
         ewa = m_cnt;
         ewd = 32'h0;
      end
      chk("rf_we", rf_we, ewe);
      chk("rf_waddr", rf_waddr, ewa);
      chk("rf_wdata", rf_wdata, ewd);
      chk("issue_ready", issue_ready, m_run);
      look(int'(rs1_addr), eb1, ef1);
      look(int'(rs2_addr), eb2, ef2);
      chk("rs1_busy", rs1_busy, eb1);
      chk("rs1_fwd", rs1_fwd, ef1);
      chk("rs2_busy", rs2_busy, eb2);
      chk("rs2_fwd", rs2_fwd, ef2);
      if (eb1) chk("rs1_tag", rs1_tag, m_tag[rs1_addr]);
      if (eb2) chk("rs2_tag", rs2_tag, m_tag[rs2_addr]);
      if (ef1) chk("rs1_fwd_data", rs1_fwd_data, commit_data);
      if (ef2) chk("rs2_fwd_data", rs2_fwd_data, commit_data);
      o_we = rf_we; o_ready = issue_ready; o_wa = rf_waddr;
      o_b1 = rs1_busy; o_f1 = rs1_fwd; o_t1 = rs1_tag; o_fd1 = rs1_fwd_data;
      o_b2 = rs2_busy;
      @(posedge clk);
      model_clock();
      #1;
   endtask

   task automatic idle();
      rdy_in = 1'b1; flush = 1'b0;
      issue_valid = 1'b0; issue_rd = '0; issue_tag = '0;
      commit_valid = 1'b0; commit_rd = '0; commit_tag = '0; commit_data = '0;
      rs1_addr = '0; rs2_addr = '0;
   endtask

   task automatic do_reset();
      rst_in = 1'b0;
      #2;
      chk("rst_rf_we", rf_we, 1'b0);
      chk("rst_rf_waddr", rf_waddr, 0);
      chk("rst_rf_wdata", rf_wdata, 0);
      chk("rst_issue_ready", issue_ready, 1'b0);
      model_reset();
      @(posedge clk);
      #1;
      rst_in = 1'b1;
   endtask

   task automatic run_init();
      idle();
      for (int i = 0; i < 100 && !m_run; i++) step();
      if (!m_run) chk("init_timeout", 1'b0, 1'b1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

   initial begin
      int we_cnt, first_ready;
      idle();
      rst_in = 1'b1;
      @(posedge clk);
      #1;
      do_reset();

      // 1: zero-init sequence length and RUN entry
      idle();
      we_cnt = 0;
      first_ready = 0;
      for (int c = 1; c <= 33; c++) begin
         step();
         if (o_we && c <= 32) we_cnt++;
         if (o_ready && first_ready == 0) first_ready = c;
      end
      chk("t1_we_cycles", we_cnt, 32);
      chk("t1_ready_cycle", first_ready, 33);

      // 2: rename, lookup, bypass, clear
      idle(); issue_valid = 1; issue_rd = 5; issue_tag = 3; step();
      idle(); rs1_addr = 5; step();
      chk("t2_busy", o_b1, 1'b1);
      chk("t2_tag", o_t1, 4'd3);
      idle(); commit_valid = 1; commit_rd = 5; commit_tag = 3; commit_data = 32'hDEADBEEF;
      rs1_addr = 5; step();
      chk("t2_fwd", o_f1, 1'b1);
      chk("t2_fwd_data", o_fd1, 32'hDEADBEEF);
      chk("t2_busy_fwd", o_b1, 1'b0);
      idle(); rs1_addr = 5; step();
      chk("t2_busy_after", o_b1, 1'b0);

      // 3: stale-tag commit writes RF only
      idle(); issue_valid = 1; issue_rd = 7; issue_tag = 2; step();
      idle(); issue_valid = 1; issue_rd = 7; issue_tag = 9; step();
      idle(); commit_valid = 1; commit_rd = 7; commit_tag = 2; commit_data = 32'h1234_5678; step();
      chk("t3_rf_we", o_we, 1'b1);
      idle(); rs1_addr = 7; step();
      chk("t3_busy", o_b1, 1'b1);
      chk("t3_tag", o_t1, 4'd9);

      // 4: issue overrides same-cycle commit clear
      idle(); issue_valid = 1; issue_rd = 4; issue_tag = 1; step();
      idle(); commit_valid = 1; commit_rd = 4; commit_tag = 1; commit_data = 32'hA5A5_0004;
      issue_valid = 1; issue_rd = 4; issue_tag = 6; step();
      chk("t4_rf_we", o_we, 1'b1);
      idle(); rs1_addr = 4; step();
      chk("t4_busy", o_b1, 1'b1);
      chk("t4_tag", o_t1, 4'd6);

      // 5: flush clears everything and drops the same-cycle issue
      idle(); issue_valid = 1; issue_rd = 3;  issue_tag = 1; step();
      idle(); issue_valid = 1; issue_rd = 8;  issue_tag = 2; step();
      idle(); issue_valid = 1; issue_rd = 12; issue_tag = 3; step();
      idle(); flush = 1; issue_valid = 1; issue_rd = 9; issue_tag = 4; step();
      idle(); rs1_addr = 3; rs2_addr = 9; step();
      chk("t5_r3_busy", o_b1, 1'b0);
      chk("t5_r9_busy", o_b2, 1'b0);
      idle(); rs1_addr = 8; rs2_addr = 12; step();
      chk("t5_r8_busy", o_b1, 1'b0);
      chk("t5_r12_busy", o_b2, 1'b0);

      // 6: pause during INIT and RUN, x0 handling
      do_reset();
      idle(); rdy_in = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("t6_init_pause_we", o_we, 1'b0);
      end
      idle(); step();
      chk("t6_init_addr0", o_wa, 0);
      run_init();
      idle(); issue_valid = 1; issue_rd = 10; issue_tag = 5; step();
      idle(); rdy_in = 0; commit_valid = 1; commit_rd = 10; commit_tag = 5; rs1_addr = 10; step();
      chk("t6_run_pause_we", o_we, 1'b0);
      chk("t6_run_pause_busy", o_b1, 1'b1);
      idle(); rs1_addr = 10; step();
      chk("t6_busy_held", o_b1, 1'b1);
      idle(); issue_valid = 1; issue_rd = 0; issue_tag = 7;
      commit_valid = 1; commit_rd = 0; commit_tag = 7; commit_data = 32'hFFFF_FFFF; step();
      chk("t6_x0_we", o_we, 1'b0);
      idle(); rs1_addr = 0; step();
      chk("t6_x0_busy", o_b1, 1'b0);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 999) == 0) do_reset();
         rdy_in       = ($urandom_range(0, 7) != 0);
         flush        = ($urandom_range(0, 31) == 0);
         issue_valid  = $urandom_range(0, 1);
         issue_rd     = $urandom_range(0, 15);
         issue_tag    = $urandom_range(0, 15);
         commit_valid = $urandom_range(0, 1);
         commit_rd    = $urandom_range(0, 15);
         commit_tag   = $urandom_range(0, 1) ? ES'(m_tag[commit_rd]) : ES'($urandom_range(0, 15));
         commit_data  = $urandom;
         rs1_addr     = $urandom_range(0, 1) ? commit_rd : ADDR_W'($urandom_range(0, 31));
         rs2_addr     = $urandom_range(0, 15);
         step();
      end

      idle();
      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
